cpu4_program_sequencer: RTL
===========================

# cpu4_program_sequencer

Program sequencer for the 4-bit CPU datapath. It holds a 16-entry program of opcode/operand words, fetches them in order, and issues datapath opcodes to the CPU core with an issue/done handshake. Control opcodes (jump, loop, halt) execute locally without touching the core. It sits between the chip-level pin inputs (program load, run control) and the CPU core's opcode/data inputs.

## Interface
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before the watchdog trips; range 1..2^WD_W-1.
- WD_W, 8: watchdog counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- prog_we  in  1  program write strobe; honoured only in IDLE or HALTED.
- prog_addr  in  4  program write address.
- prog_data  in  8  program word: [7:4] opcode, [3:0] operand.
- start  in  1  pulse: pc←0, begin run.
- resume  in  1  pulse: continue from current pc.
- abort  in  1  pulse: return to IDLE from any state.
- single  in  1  level: after each CPU instruction completes, stop in IDLE.
- cpu_done  in  1  core finished the issued instruction.
- cpu_issue  out  1  one-cycle instruction-valid to the core.
- cpu_opcode  out  4  opcode to the core; held from EXEC through WAIT.
- cpu_operand  out  4  operand to the core; same hold rule.
- pc  out  4  current program counter.
- busy  out  1  high in FETCH, EXEC and WAIT.
- halted  out  1  high in HALTED.
- error  out  1  sticky watchdog flag; cleared by start.

## Operation
- States: IDLE, FETCH, EXEC, WAIT, HALTED.
- IDLE: start → pc←0, FETCH. resume → FETCH, pc unchanged.
- FETCH: ir←mem[pc] → EXEC.
- EXEC, opcode 0x0–0xB: cpu_issue=1 → WAIT; watchdog cleared.
- EXEC, 0xC SETLC: lc←operand, pc←pc+1 → FETCH.
- EXEC, 0xD LOOP: if lc≠0 then lc←lc−1 and pc←operand; else pc←pc+1. → FETCH.
- EXEC, 0xE JMP: pc←operand → FETCH.
- EXEC, 0xF HALT: → HALTED; pc stays on the HALT word.
- WAIT: cpu_done → pc←pc+1, then IDLE if single is high, else FETCH. No done → watchdog+1. Watchdog reaching TIMEOUT_CYCLES → error←1, HALTED.
- HALTED: start → pc←0, error←0, FETCH. resume is ignored.
- Priority: abort > start > resume. abort in any state → IDLE; pc, lc and memory are kept; cpu_issue is not asserted that cycle.
- pc increments wrap 15→0. lc is 4 bits; a single loop counter, no nesting.
- prog_we while busy: ignored, memory unchanged. prog_we together with start in IDLE: the write lands first, and FETCH reads the new word.

## Timing
- Reset values:
  - state=IDLE; pc=0; lc=0; ir=0xF0; every memory word=0xF0 (HALT).
  - cpu_issue=0; cpu_opcode=0xF; cpu_operand=0.
  - busy=0; halted=0; error=0.
- start sampled at edge n: FETCH in cycle n+1, EXEC (cpu_issue high) in n+2, WAIT from n+3.
- cpu_done is sampled only in WAIT; done during EXEC is ignored. A CPU instruction therefore takes at least 3 cycles.
- Control opcodes take 2 cycles (FETCH, EXEC).
- If cpu_done arrives in the cycle the watchdog reaches its limit, done wins.
- All outputs are registered or decoded from state/ir only; there is no combinational path from input to output.

## Structure
- Package cpu4_seq_pkg holds:
  - the state enum;
  - opcode constants OP_SETLC=4'hC, OP_LOOP=4'hD, OP_JMP=4'hE, OP_HALT=4'hF;
  - the reset word 8'hF0.
- Sub-module cpu4_prog_mem: 16×8 register file, synchronous write, asynchronous read, async reset to 0xF0.
- Top level: FSM, pc/lc/ir registers, watchdog counter.

## Test plan
- Load {0x13, 0x25, 0xF0}, pulse start, core answers done 2 cycles after issue → issues opcode 1/operand 3, then opcode 2/operand 5. halted=1 with pc=2.
- Load {0xC2, 0x17, 0xD1, 0xF0}, run → opcode 1 issued exactly 3 times. lc ends at 0; halted with pc=3.
- Program {0x10, 0xF0}, core never asserts done, TIMEOUT_CYCLES=4 → error=1 and halted on the 4th WAIT cycle without done; a following start clears error.
- single=1 with program {0x11, 0x22, 0xF0} → IDLE with pc=1 after the first done; resume issues 0x2/0x2 next.
- abort during WAIT → IDLE the next cycle, busy=0, pc unchanged. prog_we pulsed during WAIT leaves memory unchanged (checked by readback run).
- Assert rst mid-WAIT → all outputs at reset values immediately, memory reads back 0xF0; a following start halts at pc=0.

Source files
------------

// File: rtl/cpu4_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu4_seq_pkg
// Description : Shared state encoding and opcode constants for the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu4_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_WAIT   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [3:0] OP_SETLC = 4'hC;
    localparam logic [3:0] OP_LOOP  = 4'hD;
    localparam logic [3:0] OP_JMP   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [7:0] c_RESET_WORD = 8'hF0;

endpackage
`default_nettype wire

// File: rtl/cpu4_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : cpu4_prog_mem
// Description : 16x8 program store, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu4_prog_mem
    import cpu4_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] r_mem [16];

    // Every word resets to HALT so an unloaded program stops immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= c_RESET_WORD;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/cpu4_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu4_program_sequencer
// Description : Fetches program words, issues datapath ops, runs control ops.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu4_program_sequencer
    import cpu4_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int WD_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic       start,
    input  logic       resume,
    input  logic       abort,
    input  logic       single,
    input  logic       cpu_done,
    output logic       cpu_issue,
    output logic [3:0] cpu_opcode,
    output logic [3:0] cpu_operand,
    output logic [3:0] pc,
    output logic       busy,
    output logic       halted,
    output logic       error
);

    localparam logic [WD_W-1:0] c_TIMEOUT = WD_W'(TIMEOUT_CYCLES);

    state_t            r_state;
    logic [3:0]        r_pc;
    logic [3:0]        r_lc;
    logic [7:0]        r_ir;
    logic [WD_W-1:0]   r_wd;
    logic              r_error;

    logic [7:0]        w_mem_word;
    logic              w_we;
    logic [3:0]        w_op;
    logic [3:0]        w_arg;
    logic [WD_W-1:0]   w_wd_next;

    assign w_we      = prog_we && (r_state == S_IDLE || r_state == S_HALTED);
    assign w_op      = r_ir[7:4];
    assign w_arg     = r_ir[3:0];
    assign w_wd_next = r_wd + 1'b1;

    cpu4_prog_mem u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (r_pc),
        .rdata (w_mem_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= 4'd0;
            r_lc    <= 4'd0;
            r_ir    <= c_RESET_WORD;
            r_wd    <= '0;
            r_error <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pc    <= 4'd0;
                        r_error <= 1'b0;
                        r_state <= S_FETCH;
                    end else if (resume) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_ir    <= w_mem_word;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (w_op)
                        OP_SETLC: begin
                            r_lc    <= w_arg;
                            r_pc    <= r_pc + 4'd1;
                            r_state <= S_FETCH;
                        end
                        OP_LOOP: begin
                            if (r_lc != 4'd0) begin
                                r_lc <= r_lc - 4'd1;
                                r_pc <= w_arg;
                            end else begin
                                r_pc <= r_pc + 4'd1;
                            end
                            r_state <= S_FETCH;
                        end
                        OP_JMP: begin
                            r_pc    <= w_arg;
                            r_state <= S_FETCH;
                        end
                        OP_HALT: begin
                            r_state <= S_HALTED;
                        end
                        default: begin
                            r_wd    <= '0;
                            r_state <= S_WAIT;
                        end
                    endcase
                end
                S_WAIT: begin
                    // A done arriving on the timeout cycle still completes normally.
                    if (cpu_done) begin
                        r_pc    <= r_pc + 4'd1;
                        r_state <= single ? S_IDLE : S_FETCH;
                    end else begin
                        r_wd <= w_wd_next;
                        if (w_wd_next == c_TIMEOUT) begin
                            r_error <= 1'b1;
                            r_state <= S_HALTED;
                        end
                    end
                end
                S_HALTED: begin
                    if (start) begin
                        r_pc    <= 4'd0;
                        r_error <= 1'b0;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Core-facing outputs decode from registered state and ir only.
    assign cpu_issue   = (r_state == S_EXEC) && (w_op < OP_SETLC);
    assign cpu_opcode  = w_op;
    assign cpu_operand = w_arg;
    assign pc          = r_pc;
    assign busy        = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_WAIT);
    assign halted      = (r_state == S_HALTED);
    assign error       = r_error;

endmodule
`default_nettype wire
